// File: rtl/pc_fetch.sv
// Program-counter / fetch sequencer: IDLE/RUN/HALT control, modular PC update and saturating taken-branch count.
// Optional one-entry call/return link register enabled by defining PC_LINK_REG_EN.
module pc_fetch #(
  parameter int unsigned D          = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          jump_abs,
  input  logic          jump_rel,
  input  logic [D-1:0]  target,
  input  logic          halt_req,
  input  logic          link_call,
  input  logic          link_ret,
  output logic [D-1:0]  prog_addr,
  output logic          valid,
  output logic          done,
  output logic [CW-1:0] taken_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t        r_state, w_state_nx;
  logic [D-1:0]  r_pc, w_pc_nx;
  logic          r_done, w_done_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [CW-1:0] w_cnt_inc;
  logic [D-1:0]  w_pc_plus1;

  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
  assign w_pc_plus1 = r_pc + D'(1);

`ifdef PC_LINK_REG_EN
  logic [D-1:0] r_link, w_link_nx;
`else
  logic w_unused_link;
  assign w_unused_link = link_call ^ link_ret;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= D'(START_ADDR);
      r_done  <= 1'b0;
      r_cnt   <= '0;
`ifdef PC_LINK_REG_EN
      r_link  <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_done  <= w_done_nx;
      r_cnt   <= w_cnt_nx;
`ifdef PC_LINK_REG_EN
      r_link  <= w_link_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_done_nx  = r_done;
    w_cnt_nx   = r_cnt;
`ifdef PC_LINK_REG_EN
    w_link_nx  = r_link;
`endif
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_state_nx = S_RUN;
          w_pc_nx    = D'(START_ADDR);
          w_cnt_nx   = '0;
          w_done_nx  = 1'b0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            w_state_nx = S_HALT;
            w_done_nx  = 1'b1;
          end
`ifdef PC_LINK_REG_EN
          else if (link_ret) begin
            w_pc_nx  = r_link;
            w_cnt_nx = w_cnt_inc;
          end
`endif
          else begin
`ifdef PC_LINK_REG_EN
            if (link_call) w_link_nx = w_pc_plus1;
`endif
            if (jump_abs) begin
              w_pc_nx  = target;
              w_cnt_nx = w_cnt_inc;
            end else if (jump_rel) begin
              w_pc_nx  = r_pc + target;
              w_cnt_nx = w_cnt_inc;
            end else begin
              w_pc_nx = w_pc_plus1;
            end
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign prog_addr = r_pc;
  assign valid     = (r_state == S_RUN);
  assign done      = r_done;
  assign taken_cnt = r_cnt;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table, saturation sequence and randomized run vs. a behavioural model.
module tb_pc_fetch;

  localparam int unsigned D  = 10;
  localparam int unsigned CW = 8;
  localparam int unsigned PCMOD  = 1 << D;
  localparam int unsigned CNTMAX = (1 << CW) - 1;
`ifdef PC_LINK_REG_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, stall, jump_abs, jump_rel, halt_req, link_call, link_ret;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_addr;
  logic          valid, done;
  logic [CW-1:0] taken_cnt;

  pc_fetch #(.D(D), .START_ADDR(0), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .jump_abs(jump_abs), .jump_rel(jump_rel), .target(target),
    .halt_req(halt_req), .link_call(link_call), .link_ret(link_ret),
    .prog_addr(prog_addr), .valid(valid), .done(done), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, st, stl, hlt, ja, jr, lc, lr;
    int unsigned tgt;
    int unsigned e_pa;
    bit          e_v, e_d;
    int unsigned e_c;
  } vec_t;

  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // behavioural model state: mode 0=idle 1=run 2=halt
  int unsigned m_mode, m_pc, m_cnt, m_link;
  bit          m_done;

  task automatic add(input bit rst, st, stl, hlt, ja, jr, lc, lr, input int unsigned tgt,
                     input int unsigned e_pa, input bit e_v, e_d, input int unsigned e_c);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.hlt = hlt; v.ja = ja; v.jr = jr;
    v.lc = lc; v.lr = lr; v.tgt = tgt;
    v.e_pa = e_pa; v.e_v = e_v; v.e_d = e_d; v.e_c = e_c;
    tbl.push_back(v);
  endtask

  task automatic drive(input bit rst, st, stl, hlt, ja, jr, lc, lr, input int unsigned tgt);
    reset = rst; start = st; stall = stl; halt_req = hlt;
    jump_abs = ja; jump_rel = jr; link_call = lc; link_ret = lr;
    target = D'(tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int unsigned e_pa, input bit e_v, e_d,
                       input int unsigned e_c);
    n_total++;
    if (prog_addr === D'(e_pa) && valid === e_v && done === e_d && taken_cnt === CW'(e_c))
      n_pass++;
    else
      $display("FAIL %s: got pa=%0d v=%b d=%b cnt=%0d, want pa=%0d v=%b d=%b cnt=%0d",
               name, prog_addr, valid, done, taken_cnt, e_pa, e_v, e_d, e_c);
  endtask

  function automatic int unsigned sat_inc(input int unsigned c);
    return (c >= CNTMAX) ? CNTMAX : c + 1;
  endfunction

  task automatic model_step(input bit rst, st, stl, hlt, ja, jr, lc, lr, input int unsigned tgt);
    if (rst) begin
      m_mode = 0; m_pc = 0; m_done = 0; m_cnt = 0; m_link = 0;
    end else if (m_mode != 1) begin
      if (st) begin
        m_mode = 1; m_pc = 0; m_cnt = 0; m_done = 0;
      end
    end else if (!stl) begin
      if (hlt) begin
        m_mode = 2; m_done = 1;
      end else if (LINK && lr) begin
        m_pc = m_link; m_cnt = sat_inc(m_cnt);
      end else begin
        if (LINK && lc) m_link = (m_pc + 1) % PCMOD;
        if (ja)      begin m_pc = tgt;                   m_cnt = sat_inc(m_cnt); end
        else if (jr) begin m_pc = (m_pc + tgt) % PCMOD;  m_cnt = sat_inc(m_cnt); end
        else               m_pc = (m_pc + 1) % PCMOD;
      end
    end
  endtask

  initial begin
    // Directed table: each row's expectations are the outputs after that row's clock edge.
    add(0,1,0,0,0,0,0,0, 0,     0, 1,0, 0);
    for (int i = 1; i <= 10; i++) add(0,0,0,0,0,0,0,0, 0, i, 1,0, 0);
    add(0,0,0,1,0,0,0,0, 0,    10, 0,1, 0);
    add(0,1,0,0,0,0,0,0, 0,     0, 1,0, 0);
    for (int i = 1; i <= 5; i++) add(0,0,0,0,0,0,0,0, 0, i, 1,0, 0);
    add(0,0,0,0,1,0,0,0, 43,   43, 1,0, 1);
    add(0,0,0,0,0,1,0,0, 1023, 42, 1,0, 2);
    add(0,0,0,0,1,0,0,0, 1023, 1023, 1,0, 3);
    add(0,0,0,0,0,0,0,0, 0,     0, 1,0, 3);
    add(0,0,0,0,0,1,0,0, 1022, 1022, 1,0, 4);
    add(0,0,0,0,1,0,0,0, 20,   20, 1,0, 5);
    add(0,0,0,0,1,1,0,0, 89,   89, 1,0, 6);
    for (int i = 0; i < 3; i++) add(0,0,1,1,1,0,0,0, 7, 89, 1,0, 6);
    add(0,0,0,1,1,0,0,0, 7,    89, 0,1, 6);
    add(0,0,0,0,1,0,0,0, 7,    89, 0,1, 6);
    add(0,1,0,0,1,0,0,0, 7,     0, 1,0, 0);
    add(0,1,0,0,0,0,0,0, 0,     1, 1,0, 0);
    add(0,0,0,0,1,0,0,0, 7,     7, 1,0, 1);
    add(0,0,0,0,1,0,1,0, 74,   74, 1,0, 2);
    add(0,0,0,0,0,0,0,1, 0, LINK ? 8 : 75, 1,0, LINK ? 3 : 2);
    add(1,0,0,0,1,0,0,0, 300,   0, 0,0, 0);
    add(0,0,0,1,1,1,0,0, 300,   0, 0,0, 0);
    add(0,0,1,0,0,0,0,0, 0,     0, 0,0, 0);

    drive(1,0,0,0,0,0,0,0, 0);
    drive(1,0,0,0,0,0,0,0, 0);
    check("reset", 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].stl, tbl[i].hlt, tbl[i].ja, tbl[i].jr,
            tbl[i].lc, tbl[i].lr, tbl[i].tgt);
      check($sformatf("vec%0d", i), tbl[i].e_pa, tbl[i].e_v, tbl[i].e_d, tbl[i].e_c);
    end

    // Saturation: 260 taken jumps must pin the count at its maximum.
    drive(0,1,0,0,0,0,0,0, 0);
    for (int i = 0; i < 260; i++) begin
      drive(0,0,0,0,1,0,0,0, i + 100);
      if (i >= 250) check($sformatf("sat%0d", i), (i + 100) % PCMOD, 1, 0,
                          (i + 1 > CNTMAX) ? CNTMAX : i + 1);
    end
    drive(0,0,0,0,0,1,0,0, 5);
    check("sat_rel", (359 + 5) % PCMOD, 1, 0, CNTMAX);

    // Randomized run against the behavioural model.
    drive(1,0,0,0,0,0,0,0, 0);
    model_step(1,0,0,0,0,0,0,0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit rst, st, stl, hlt, ja, jr, lc, lr;
      int unsigned tgt;
      rst = ($urandom_range(63) == 0);
      st  = ($urandom_range(11) == 0);
      stl = (m_mode == 1) && ($urandom_range(3) == 0);
      hlt = ($urandom_range(39) == 0);
      ja  = ($urandom_range(4) == 0);
      jr  = ($urandom_range(4) == 0);
      lc  = (ja || jr) && ($urandom_range(3) == 0);
      lr  = ($urandom_range(9) == 0);
      tgt = $urandom_range(PCMOD - 1);
      drive(rst, st, stl, hlt, ja, jr, lc, lr, tgt);
      model_step(rst, st, stl, hlt, ja, jr, lc, lr, tgt);
      check($sformatf("rand%0d", i), m_pc, (m_mode == 1), m_done, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
